// File: rtl/fft_load_seq.sv
// Loads 16 streamed samples into a 1-to-16 lane demux in natural or bit-reversed order,
// then holds the completed frame until the consumer acknowledges it.
module fft_load_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             bitrev_en,
  output logic [3:0]       sel0,
  output logic [WIDTH-1:0] data_out,
  output logic             wr_en,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             frame_err,
  output logic [7:0]       frame_cnt,
  output logic             dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready depends only on state (and rst), never on in_valid.
  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             brev_q, brev_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q;
  logic             wr_en_q;
  logic             frame_valid_q;
  logic             frame_err_q;
  logic [7:0]       frame_cnt_q;
  logic             accept;

  assign in_ready = (state_q == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  // Lane order is latched on the first sample so mid-frame toggles cannot scramble a frame.
  always_comb begin
    brev_d = brev_q;
    if (cnt_q == 4'd0) brev_d = bitrev_en;
    sel_d = brev_d ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]} : cnt_q;
    cnt_d = cnt_q + 4'd1;
    if ((cnt_q == 4'd15) || in_last) cnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt_q         <= 4'd0;
      brev_q        <= 1'b0;
      sel_q         <= 4'd0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            brev_q  <= brev_d;
            sel_q   <= sel_d;
            data_q  <= in_data;
            wr_en_q <= 1'b1;
            cnt_q   <= cnt_d;
            if (cnt_q == 4'd15) begin
              state_q       <= FULL;
              frame_valid_q <= 1'b1;
              frame_cnt_q   <= frame_cnt_q + 8'd1;
            end else if (in_last) begin
              // Short frame: written lanes stay, but the frame is never presented.
              frame_err_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (frame_ack) begin
            state_q       <= LOAD;
            frame_valid_q <= 1'b0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign sel0        = sel_q;
  assign data_out    = data_q;
  assign wr_en       = wr_en_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_load_seq.sv
// Bench for fft_load_seq: driver tasks push expected {frame_valid, sel0, data_out}
// entries; a negedge monitor pops and compares them on every wr_en.
module tb_fft_load_seq;
  localparam int W  = 32;
  localparam int QW = W + 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         bitrev_en;
  logic [3:0]   sel0;
  logic [W-1:0] data_out;
  logic         wr_en;
  logic         frame_valid;
  logic         frame_ack;
  logic         frame_err;
  logic [7:0]   frame_cnt;
  logic         dbg_state;

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_e;
  logic [3:0]    br_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
  int vectors = 0;
  int errors  = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_load_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .bitrev_en(bitrev_en), .sel0(sel0), .data_out(data_out),
    .wr_en(wr_en), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {60'd0, sel0}, 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr", {27'd0, frame_valid, sel0, data_out}, {27'd0, mon_e});
      end
    end
  end

  // driver tasks: called and return at posedge+1
  task automatic send(input logic [W-1:0] d, input logic last, input logic br,
                      input logic [3:0] es, input logic fv);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; bitrev_en = br;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    else exp_q.push_back({fv, es, d});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) send($urandom, 1'b0, 1'b0, i[3:0], i == 15);
    idle();
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel0"}, {60'd0, sel0}, 64'd0);
    chk({tag, "_data"}, {32'd0, data_out}, 64'd0);
    chk({tag, "_wr"}, {63'd0, wr_en}, 64'd0);
    chk({tag, "_fv"}, {63'd0, frame_valid}, 64'd0);
    chk({tag, "_err"}, {63'd0, frame_err}, 64'd0);
    chk({tag, "_cnt"}, {56'd0, frame_cnt}, 64'd0);
    chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    bitrev_en = 1'b0; frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // natural-order frame, data equals lane index
    for (int i = 0; i < 16; i++) send(i, 1'b0, 1'b0, i[3:0], i == 15);
    in_data = 32'hAA;
    @(negedge clk);
    chk("a_rdy", {63'd0, in_ready}, 64'd0);
    chk("a_fv", {63'd0, frame_valid}, 64'd1);
    chk("a_cnt", {56'd0, frame_cnt}, 64'd1);
    // in_valid stays high in FULL without ack: no writes, frame held
    repeat (10) begin
      @(negedge clk);
      chk("full_hold_fv", {63'd0, frame_valid}, 64'd1);
    end
    @(posedge clk); #1;
    ack_frame();
    @(negedge clk);
    chk("ack_fv", {63'd0, frame_valid}, 64'd0);
    chk("ack_rdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // bit-reversed frame, bitrev_en toggled mid-frame
    for (int i = 0; i < 16; i++)
      send($urandom, 1'b0, (i == 0) ? 1'b1 : i[0], br_tab[i], i == 15);
    idle();
    @(negedge clk);
    chk("b_cnt", {56'd0, frame_cnt}, 64'd2);
    @(posedge clk); #1;
    ack_frame();

    // early in_last on 5th sample
    for (int i = 0; i < 5; i++) send($urandom, i == 4, 1'b0, i[3:0], 1'b0);
    idle();
    @(negedge clk);
    chk("short_err", {63'd0, frame_err}, 64'd1);
    chk("short_fv", {63'd0, frame_valid}, 64'd0);
    chk("short_cnt", {56'd0, frame_cnt}, 64'd2);
    chk("short_rdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send_frame();
    chk("after_short_cnt", {56'd0, frame_cnt}, 64'd3);
    chk("after_short_fv", {63'd0, frame_valid}, 64'd1);
    ack_frame();

    // reset after 7 accepts discards the partial frame
    for (int i = 0; i < 7; i++) send($urandom, 1'b0, 1'b1, br_tab[i], 1'b0);
    rst = 1'b1; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_mid_rst", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send_frame();
    chk("post_rst_cnt", {56'd0, frame_cnt}, 64'd1);
    ack_frame();

    // 255 more frames, ack in first FULL cycle: frame_cnt wraps to 0
    for (int f = 1; f < 256; f++) begin
      send_frame();
      if (f == 254) chk("cnt_255", {56'd0, frame_cnt}, 64'd255);
      ack_frame();
    end
    chk("cnt_wrap", {56'd0, frame_cnt}, 64'd0);

    repeat (3) @(negedge clk);
    chk("q_empty", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
